// File: rtl/coherent_bus_ctrl_pkg.sv
// Shared types for the coherent bus controller: RAM handshake states, bus FSM
// states and the bundled RAM request driven by the controller.
package coherent_bus_ctrl_pkg;

    // Default number of core/cache pairs; the top exposes this as a parameter.
    localparam int CACHES = 2;

    // Words moved per cache block; the two-beat FSM is built around this value.
    localparam int BLK_WORDS = 2;

    // Handshake state reported by the RAM model each cycle.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Bus transaction states. Every block transfer is two beats long, hence
    // the paired states.
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        WB1    = 4'd1,
        WB2    = 4'd2,
        SNOOP  = 4'd3,
        MEMRD1 = 4'd4,
        MEMRD2 = 4'd5,
        C2C1   = 4'd6,
        C2C2   = 4'd7,
        IMEM   = 4'd8
    } bus_state_t;

    // Everything the controller presents on the single RAM port.
    typedef struct packed {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
    } ram_req_t;

    // Beat completes only on ACCESS; ERROR deliberately behaves like BUSY.
    function automatic logic ram_done(input ramstate_t st);
        return st == ACCESS;
    endfunction

endpackage

// File: rtl/coherent_bus_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request found
// scanning upward from the slot after the last winner, wrapping at N.
// The pointer register lives in the parent so it can update only on a grant.
module coherent_bus_ctrl_rr_arbiter #(
    parameter int N = 2,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant,
    output logic         valid
);

    logic [W-1:0] cand;

    // Scan ptr+1 .. ptr+N (mod N); the first hit wins, ptr itself is checked last.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment, otherwise synthesis infers a latch.
        grant = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 1; i <= N; i++) begin
            cand = W'((int'(ptr) + i) % N);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                grant = cand;
            end
        end
    end

endmodule

// File: rtl/coherent_bus_ctrl.sv
// Coherent bus controller: arbitrates CACHES icache/dcache pairs onto one RAM
// port, broadcasts snoops to the other dcaches on a miss and performs
// cache-to-cache transfers while writing the supplied block back to RAM.
module coherent_bus_ctrl #(
    parameter int CACHES    = coherent_bus_ctrl_pkg::CACHES,
    parameter int ARB_W     = $clog2(CACHES),
    parameter int BLK_WORDS = coherent_bus_ctrl_pkg::BLK_WORDS
) (
    input  logic                             CLK,
    input  logic                             nRST,
    // dcache side
    input  logic [CACHES-1:0]                dREN,
    input  logic [CACHES-1:0]                dWEN,
    input  logic [CACHES-1:0][31:0]          daddr,
    input  logic [CACHES-1:0][31:0]          dstore,
    input  logic [CACHES-1:0]                ccwrite,
    input  logic [CACHES-1:0]                cctrans,
    output logic [CACHES-1:0]                dwait,
    output logic [CACHES-1:0][31:0]          dload,
    output logic [CACHES-1:0]                ccwait,
    output logic [CACHES-1:0]                ccinv,
    output logic [CACHES-1:0][31:0]          ccsnoopaddr,
    // icache side
    input  logic [CACHES-1:0]                iREN,
    input  logic [CACHES-1:0][31:0]          iaddr,
    output logic [CACHES-1:0]                iwait,
    output logic [CACHES-1:0][31:0]          iload,
    // RAM port
    output logic                             ramREN,
    output logic                             ramWEN,
    output logic [31:0]                      ramaddr,
    output logic [31:0]                      ramstore,
    input  logic [31:0]                      ramload,
    input  coherent_bus_ctrl_pkg::ramstate_t ramstate
);

    import coherent_bus_ctrl_pkg::*;

    // The FSM has exactly two beat states per block; any other width is unsupported.
    if (BLK_WORDS != 2) begin : g_blk_words_check
        $error("coherent_bus_ctrl supports only BLK_WORDS == 2");
    end

    bus_state_t       state;
    bus_state_t       next_state;

    logic [ARB_W-1:0] d_ptr;
    logic [ARB_W-1:0] i_ptr;
    logic [ARB_W-1:0] grant;
    logic [ARB_W-1:0] supplier;

    logic [CACHES-1:0] d_req;
    logic [ARB_W-1:0]  d_gnt;
    logic              d_valid;
    logic [ARB_W-1:0]  i_gnt;
    logic              i_valid;

    logic              supply_valid;
    logic [ARB_W-1:0]  supply_idx;
    logic              access;

    ram_req_t          ram;

    // A write-back and a miss both compete in the dcache class.
    assign d_req  = dREN | dWEN;
    assign access = ram_done(ramstate);

    coherent_bus_ctrl_rr_arbiter #(.N(CACHES), .W(ARB_W)) u_d_arb (
        .req   (d_req),
        .ptr   (d_ptr),
        .grant (d_gnt),
        .valid (d_valid)
    );

    coherent_bus_ctrl_rr_arbiter #(.N(CACHES), .W(ARB_W)) u_i_arb (
        .req   (iREN),
        .ptr   (i_ptr),
        .grant (i_gnt),
        .valid (i_valid)
    );

    // Pick the lowest-numbered snooper (other than the requester) holding the block Modified.
    always_comb begin
        supply_valid = 1'b0;
        supply_idx   = '0;
        for (int k = CACHES - 1; k >= 0; k--) begin
            if (k != int'(grant) && cctrans[k]) begin
                supply_valid = 1'b1;
                supply_idx   = ARB_W'(k);
            end
        end
    end

    // State, round-robin pointers, held grant and latched supplier.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            d_ptr    <= '0;
            i_ptr    <= '0;
            grant    <= '0;
            supplier <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every register
            // samples pre-edge values, independent of statement order.
            state <= next_state;
            if (state == IDLE) begin
                if (d_valid) begin
                    d_ptr <= d_gnt;
                    grant <= d_gnt;
                end else if (i_valid) begin
                    i_ptr <= i_gnt;
                    grant <= i_gnt;
                end
            end
            if (state == SNOOP) begin
                supplier <= supply_idx;
            end
        end
    end

    // Next-state: dcache class beats icache; write-back beats miss for the same cache.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (d_valid) begin
                    next_state = dWEN[d_gnt] ? WB1 : SNOOP;
                end else if (i_valid) begin
                    next_state = IMEM;
                end
            end
            WB1:    if (access) next_state = WB2;
            WB2:    if (access) next_state = IDLE;
            SNOOP:  next_state = supply_valid ? C2C1 : MEMRD1;
            C2C1:   if (access) next_state = C2C2;
            C2C2:   if (access) next_state = IDLE;
            MEMRD1: if (access) next_state = MEMRD2;
            MEMRD2: if (access) next_state = IDLE;
            IMEM:   if (access) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs: snoop lines to every non-requesting dcache, RAM request and wait release.
    always_comb begin
        dwait       = '1;
        iwait       = '1;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        dload       = '0;
        iload       = '0;
        ram         = '0;

        // Snoopers stay stalled from the broadcast through the end of a C2C transfer.
        if (state == SNOOP || state == C2C1 || state == C2C2) begin
            for (int k = 0; k < CACHES; k++) begin
                if (k != int'(grant)) begin
                    ccwait[k]      = 1'b1;
                    ccsnoopaddr[k] = daddr[grant];
                    ccinv[k]       = ccwrite[grant];
                end
            end
        end

        unique case (state)
            WB1, WB2: begin
                ram.wen   = 1'b1;
                ram.addr  = daddr[grant];
                ram.store = dstore[grant];
                if (access) dwait[grant] = 1'b0;
            end
            C2C1, C2C2: begin
                // Supplier data goes to the requester and to RAM in the same beat.
                ram.wen      = 1'b1;
                ram.addr     = daddr[supplier];
                ram.store    = dstore[supplier];
                dload[grant] = dstore[supplier];
                if (access) begin
                    dwait[grant]    = 1'b0;
                    dwait[supplier] = 1'b0;
                end
            end
            MEMRD1, MEMRD2: begin
                ram.ren      = 1'b1;
                ram.addr     = daddr[grant];
                dload[grant] = ramload;
                if (access) dwait[grant] = 1'b0;
            end
            IMEM: begin
                ram.ren      = 1'b1;
                ram.addr     = iaddr[grant];
                iload[grant] = ramload;
                if (access) iwait[grant] = 1'b0;
            end
            default: ;
        endcase
    end

    assign ramREN   = ram.ren;
    assign ramWEN   = ram.wen;
    assign ramaddr  = ram.addr;
    assign ramstore = ram.store;

endmodule

// File: tb/tb_coherent_bus_ctrl.sv
// Self-checking bench for coherent_bus_ctrl with four caches and a two-cycle
// latency RAM model. Every completed word is compared against a queue of
// expectations pushed when the stimulus is driven.
module tb_coherent_bus_ctrl;

    import coherent_bus_ctrl_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 2;

    logic                CLK = 1'b0;
    logic                nRST;
    logic [N-1:0]        dREN, dWEN, ccwrite, cctrans, iREN;
    logic [N-1:0][31:0]  daddr, dstore, iaddr;
    logic [N-1:0]        dwait, ccwait, ccinv, iwait;
    logic [N-1:0][31:0]  dload, ccsnoopaddr, iload;
    logic                ramREN, ramWEN;
    logic [31:0]         ramaddr, ramstore, ramload;
    ramstate_t           ramstate;

    int n_checks = 0;
    int n_errors = 0;
    int pulse_cnt = 0;
    int busy_run = 0;

    typedef struct {
        string       name;
        logic [3:0]  dw;
        logic [3:0]  iw;
        int          idx;
        bit          is_i;
        bit          chk_load;
        logic [31:0] load;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] data;
    } sb_entry_t;

    sb_entry_t sb[$];

    typedef struct {
        int          g;
        logic        ccw;
        logic [3:0]  trans;
        logic [31:0] addr;
        logic [31:0] st0;
        logic [31:0] st1;
        logic [3:0]  exp_ccwait;
        logic [3:0]  exp_ccinv;
        int          exp_sup;
    } miss_vec_t;

    miss_vec_t vecs [5];

    logic [31:0] mem [1024];
    int          ram_cnt = 0;

    always #5 CLK = ~CLK;

    coherent_bus_ctrl #(.CACHES(N)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .daddr       (daddr),
        .dstore      (dstore),
        .ccwrite     (ccwrite),
        .cctrans     (cctrans),
        .dwait       (dwait),
        .dload       (dload),
        .ccwait      (ccwait),
        .ccinv       (ccinv),
        .ccsnoopaddr (ccsnoopaddr),
        .iREN        (iREN),
        .iaddr       (iaddr),
        .iwait       (iwait),
        .iload       (iload),
        .ramREN      (ramREN),
        .ramWEN      (ramWEN),
        .ramaddr     (ramaddr),
        .ramstore    (ramstore),
        .ramload     (ramload),
        .ramstate    (ramstate)
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'h5A00_0000 ^ a;
    endfunction

    // RAM model: LAT BUSY cycles then one ACCESS cycle per word.
    assign ramstate = !(ramREN || ramWEN) ? FREE : ((ram_cnt == LAT) ? ACCESS : BUSY);
    assign ramload  = mem[ramaddr[11:2]];

    always @(posedge CLK) begin
        if (ramREN || ramWEN) begin
            if (ram_cnt == LAT) begin
                ram_cnt <= 0;
                if (ramWEN) mem[ramaddr[11:2]] <= ramstore;
            end else begin
                ram_cnt <= ram_cnt + 1;
            end
        end else begin
            ram_cnt <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input string name, input logic [3:0] dw, input logic [3:0] iw,
                            input int idx, input bit is_i, input bit chk_load,
                            input logic [31:0] load, input bit wen,
                            input logic [31:0] addr, input logic [31:0] data);
        sb_entry_t e;
        e.name = name; e.dw = dw; e.iw = iw; e.idx = idx; e.is_i = is_i;
        e.chk_load = chk_load; e.load = load; e.wen = wen; e.addr = addr; e.data = data;
        sb.push_back(e);
    endtask

    // Monitor: any released wait is a completed word; compare it with the queue head.
    always @(negedge CLK) begin
        sb_entry_t e;
        if (dwait !== '1 || iwait !== '1) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {dwait, iwait}, 8'hFF);
            end else begin
                e = sb.pop_front();
                check({e.name, "_dwait"}, dwait, e.dw);
                check({e.name, "_iwait"}, iwait, e.iw);
                check({e.name, "_ramwen"}, ramWEN, e.wen);
                check({e.name, "_ramren"}, ramREN, !e.wen);
                check({e.name, "_ramaddr"}, ramaddr, e.addr);
                if (e.wen) check({e.name, "_ramstore"}, ramstore, e.data);
                if (e.chk_load) begin
                    if (e.is_i) check({e.name, "_iload"}, iload[e.idx], e.load);
                    else        check({e.name, "_dload"}, dload[e.idx], e.load);
                end
                check({e.name, "_busy_cycles"}, busy_run, LAT);
            end
            pulse_cnt++;
            busy_run = 0;
        end else if (ramstate == BUSY) begin
            busy_run++;
        end else begin
            busy_run = 0;
        end
    end

    // Returns on the clock edge that completes the target-th word overall.
    task automatic wait_pulses(input int target, input string name);
        int cyc = 0;
        while (pulse_cnt < target && cyc < 300) begin
            @(posedge CLK);
            cyc++;
        end
        if (pulse_cnt < target) check({name, "_timeout"}, pulse_cnt, target);
    endtask

    task automatic wait_snoop(input int g, input logic [3:0] exp_w, input logic [3:0] exp_i,
                              input logic [31:0] a, input string name);
        int cyc = 0;
        @(negedge CLK);
        while (ccwait == '0 && cyc < 50) begin
            @(negedge CLK);
            cyc++;
        end
        check({name, "_ccwait"}, ccwait, exp_w);
        check({name, "_ccinv"}, ccinv, exp_i);
        for (int k = 0; k < N; k++)
            if (k != g) check({name, "_snoopaddr"}, ccsnoopaddr[k], a);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [3:0] dwv;
        logic [3:0] iw_order [5];

        vecs[0] = '{g:2, ccw:1'b0, trans:4'b0000, addr:32'h100, st0:32'h0, st1:32'h0,
                    exp_ccwait:4'b1011, exp_ccinv:4'b0000, exp_sup:-1};
        vecs[1] = '{g:1, ccw:1'b1, trans:4'b1000, addr:32'h140, st0:32'hDEADBEEF, st1:32'hCAFEF00D,
                    exp_ccwait:4'b1101, exp_ccinv:4'b1101, exp_sup:3};
        vecs[2] = '{g:2, ccw:1'b0, trans:4'b1001, addr:32'h180, st0:32'h12345678, st1:32'h9ABCDEF0,
                    exp_ccwait:4'b1011, exp_ccinv:4'b0000, exp_sup:0};
        vecs[3] = '{g:0, ccw:1'b1, trans:4'b0000, addr:32'h1C0, st0:32'h0, st1:32'h0,
                    exp_ccwait:4'b1110, exp_ccinv:4'b1110, exp_sup:-1};
        vecs[4] = '{g:3, ccw:1'b0, trans:4'b1000, addr:32'h1E0, st0:32'h0, st1:32'h0,
                    exp_ccwait:4'b0111, exp_ccinv:4'b0000, exp_sup:-1};
        iw_order = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};

        for (int a = 0; a < 1024; a++) mem[a] = pat(32'(a * 4));

        nRST = 1'b0;
        dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0; iREN = '0;
        daddr = '0; dstore = '0; iaddr = '0;
        for (int k = 0; k < N; k++) iaddr[k] = 32'h200 + 32'(16 * k);

        // Reset state.
        repeat (2) @(negedge CLK);
        check("rst_dwait", dwait, 4'b1111);
        check("rst_iwait", iwait, 4'b1111);
        check("rst_ccwait", ccwait, 4'b0000);
        check("rst_ccinv", ccinv, 4'b0000);
        check("rst_ramren", ramREN, 1'b0);
        check("rst_ramwen", ramWEN, 1'b0);
        check("rst_ramaddr", ramaddr, 32'h0);
        check("rst_ramstore", ramstore, 32'h0);
        for (int k = 0; k < N; k++) begin
            check("rst_dload", dload[k], 32'h0);
            check("rst_iload", iload[k], 32'h0);
            check("rst_snoopaddr", ccsnoopaddr[k], 32'h0);
        end
        @(posedge CLK); #1 nRST = 1'b1;
        repeat (2) @(posedge CLK); #1;

        // All icaches requesting: round-robin order 1,2,3,0,1.
        base = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            int k;
            k = (i + 1) % N;
            push_exp("irr", 4'b1111, iw_order[i], k, 1'b1, 1'b1, pat(iaddr[k]), 1'b0, iaddr[k], 32'h0);
        end
        iREN = 4'b1111;
        wait_pulses(base + 5, "irr");
        #1 iREN = '0;
        repeat (2) @(posedge CLK); #1;

        // dcache miss has priority over a simultaneous icache fetch.
        base = pulse_cnt;
        daddr[2] = 32'h100;
        push_exp("prio_d0", 4'b1011, 4'b1111, 2, 1'b0, 1'b1, pat(32'h100), 1'b0, 32'h100, 32'h0);
        push_exp("prio_d1", 4'b1011, 4'b1111, 2, 1'b0, 1'b1, pat(32'h104), 1'b0, 32'h104, 32'h0);
        push_exp("prio_i", 4'b1111, 4'b1110, 0, 1'b1, 1'b1, pat(32'h200), 1'b0, 32'h200, 32'h0);
        dREN[2] = 1'b1;
        iREN[0] = 1'b1;
        wait_snoop(2, 4'b1011, 4'b0000, 32'h100, "prio_snoop");
        wait_pulses(base + 1, "prio_d0");
        #1 daddr[2] = 32'h104;
        wait_pulses(base + 2, "prio_d1");
        #1 dREN[2] = 1'b0;
        wait_pulses(base + 3, "prio_i");
        #1 iREN[0] = 1'b0;
        repeat (2) @(posedge CLK); #1;

        // Table-driven misses: memory fill, C2C with BusRdX, supplier priority, own cctrans ignored.
        for (int v = 0; v < 5; v++) begin
            int g, s;
            g = vecs[v].g;
            s = vecs[v].exp_sup;
            base = pulse_cnt;
            daddr[g]   = vecs[v].addr;
            ccwrite[g] = vecs[v].ccw;
            cctrans    = vecs[v].trans;
            if (s >= 0) begin
                daddr[s]  = vecs[v].addr;
                dstore[s] = vecs[v].st0;
                dwv = 4'b1111;
                dwv[g] = 1'b0;
                dwv[s] = 1'b0;
                push_exp($sformatf("vec%0d_w0", v), dwv, 4'b1111, g, 1'b0, 1'b1, vecs[v].st0,
                         1'b1, vecs[v].addr, vecs[v].st0);
                push_exp($sformatf("vec%0d_w1", v), dwv, 4'b1111, g, 1'b0, 1'b1, vecs[v].st1,
                         1'b1, vecs[v].addr + 4, vecs[v].st1);
            end else begin
                dwv = 4'b1111;
                dwv[g] = 1'b0;
                push_exp($sformatf("vec%0d_w0", v), dwv, 4'b1111, g, 1'b0, 1'b1, pat(vecs[v].addr),
                         1'b0, vecs[v].addr, 32'h0);
                push_exp($sformatf("vec%0d_w1", v), dwv, 4'b1111, g, 1'b0, 1'b1, pat(vecs[v].addr + 4),
                         1'b0, vecs[v].addr + 4, 32'h0);
            end
            dREN[g] = 1'b1;
            wait_snoop(g, vecs[v].exp_ccwait, vecs[v].exp_ccinv, vecs[v].addr, $sformatf("vec%0d", v));
            wait_pulses(base + 1, $sformatf("vec%0d_w0", v));
            #1 daddr[g] = vecs[v].addr + 4;
            if (s >= 0) begin
                daddr[s]  = vecs[v].addr + 4;
                dstore[s] = vecs[v].st1;
            end
            wait_pulses(base + 2, $sformatf("vec%0d_w1", v));
            #1 dREN = '0; ccwrite = '0; cctrans = '0;
            repeat (2) @(posedge CLK); #1;
        end

        // Write-back and miss from the same cache: write-back first, then read it back.
        base = pulse_cnt;
        push_exp("wb_w0", 4'b1110, 4'b1111, 0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 32'h11110000);
        push_exp("wb_w1", 4'b1110, 4'b1111, 0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h304, 32'h22220000);
        push_exp("wbrd_w0", 4'b1110, 4'b1111, 0, 1'b0, 1'b1, 32'h11110000, 1'b0, 32'h300, 32'h0);
        push_exp("wbrd_w1", 4'b1110, 4'b1111, 0, 1'b0, 1'b1, 32'h22220000, 1'b0, 32'h304, 32'h0);
        daddr[0]  = 32'h300;
        dstore[0] = 32'h11110000;
        dWEN[0] = 1'b1;
        dREN[0] = 1'b1;
        wait_pulses(base + 1, "wb_w0");
        #1 daddr[0] = 32'h304; dstore[0] = 32'h22220000;
        wait_pulses(base + 2, "wb_w1");
        #1 dWEN[0] = 1'b0; daddr[0] = 32'h300;
        wait_snoop(0, 4'b1110, 4'b0000, 32'h300, "wbrd");
        wait_pulses(base + 3, "wbrd_w0");
        #1 daddr[0] = 32'h304;
        wait_pulses(base + 4, "wbrd_w1");
        #1 dREN[0] = 1'b0;
        repeat (2) @(posedge CLK); #1;

        // Reset during the second memory read beat, then the reissued miss restarts cleanly.
        base = pulse_cnt;
        push_exp("rstm_w0", 4'b1101, 4'b1111, 1, 1'b0, 1'b1, pat(32'h400), 1'b0, 32'h400, 32'h0);
        daddr[1] = 32'h400;
        dREN[1] = 1'b1;
        wait_snoop(1, 4'b1101, 4'b0000, 32'h400, "rstm");
        wait_pulses(base + 1, "rstm_w0");
        #1 daddr[1] = 32'h404;
        @(negedge CLK);
        check("rstm_memrd2_ren", ramREN, 1'b1);
        check("rstm_memrd2_addr", ramaddr, 32'h404);
        @(posedge CLK); #1 nRST = 1'b0;
        @(negedge CLK);
        check("rstm_dwait", dwait, 4'b1111);
        check("rstm_ramren", ramREN, 1'b0);
        check("rstm_ccwait", ccwait, 4'b0000);
        @(posedge CLK); #1 daddr[1] = 32'h400;
        @(posedge CLK); #1 nRST = 1'b1;
        check("rstm_no_partial_word", pulse_cnt, base + 1);
        push_exp("rstm_re_w0", 4'b1101, 4'b1111, 1, 1'b0, 1'b1, pat(32'h400), 1'b0, 32'h400, 32'h0);
        push_exp("rstm_re_w1", 4'b1101, 4'b1111, 1, 1'b0, 1'b1, pat(32'h404), 1'b0, 32'h404, 32'h0);
        wait_snoop(1, 4'b1101, 4'b0000, 32'h400, "rstm_re");
        wait_pulses(base + 2, "rstm_re_w0");
        #1 daddr[1] = 32'h404;
        wait_pulses(base + 3, "rstm_re_w1");
        #1 dREN[1] = 1'b0;
        repeat (3) @(posedge CLK);

        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/coherent_bus_ctrl.md
Name: coherent_bus_ctrl

Overview:
- Next-generation memory/coherence controller between CACHES private L1 pairs (icache + dcache) and one shared RAM port.
- Generalises the two-cache controller to N caches:
  - round-robin arbitration per port class;
  - snoop broadcast to all non-requesting dcaches;
  - cache-to-cache transfer with simultaneous RAM write-back.
- Sits between the per-core caches and the RAM model in the system top.

Parameters:
CACHES, 2, number of cores/cache pairs (>=2, any integer)
ARB_W, $clog2(CACHES), width of grant index / round-robin pointer
BLK_WORDS, 2, words per cache block transferred per bus transaction (fixed by dcache format, must be 2)

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
dREN  in  CACHES  dcache read miss request per cache
dWEN  in  CACHES  dcache write-back request per cache
daddr  in  CACHES x 32  word address per dcache
dstore  in  CACHES x 32  write-back / snoop-supply data per dcache
ccwrite  in  CACHES  requester: miss is for write (BusRdX); snooper: unused
cctrans  in  CACHES  snooper: holds block Modified and will supply it
dwait  out  CACHES  low for one cycle when the current word completes
dload  out  CACHES x 32  read data to requester
ccwait  out  CACHES  high to each snooped cache during a snoop transaction
ccinv  out  CACHES  invalidate snooped block (BusRdX)
ccsnoopaddr  out  CACHES x 32  snoop address (requester's daddr) to each cache
iREN  in  CACHES  icache read request
iaddr  in  CACHES x 32  icache address
iwait  out  CACHES  low for one cycle when the instruction word returns
iload  out  CACHES x 32  instruction data
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR from RAM

Behaviour:
- Reset (async, nRST low):
  - state=IDLE, both RR pointers=0;
  - dwait/iwait all 1, ccwait/ccinv 0;
  - ram* 0, dload/iload/ccsnoopaddr 0.
  - Any in-flight transaction is abandoned; no partial word completes.
- Arbitration, evaluated in IDLE only:
  - Any dREN|dWEN pending -> dcache class wins.
  - Otherwise any iREN -> icache class.
  - Within a class, grant the first requester scanning from ptr+1 mod CACHES.
  - On grant, that class's ptr = grant index; the grant is held until the transaction returns to IDLE.
  - dWEN beats dREN from the same cache.
- States: IDLE, WB1, WB2, SNOOP, MEMRD1, MEMRD2, C2C1, C2C2, IMEM.
- Write-back (WB1->WB2->IDLE):
  - ramWEN=1, ramaddr=daddr[g], ramstore=dstore[g].
  - On ramstate==ACCESS: dwait[g]=0 that cycle, advance.
- Miss (SNOOP, 1 cycle):
  - For all k!=g: ccwait[k]=1, ccsnoopaddr[k]=daddr[g], ccinv[k]=ccwrite[g].
  - Next cycle (ccwait still held): any cctrans[k], k!=g -> C2C1, supplier s = lowest such index; none -> MEMRD1.
- C2C1/C2C2:
  - ramWEN=1, ramaddr=daddr[s], ramstore=dstore[s], dload[g]=dstore[s].
  - On ACCESS: dwait[g]=0 and dwait[s]=0 that cycle, advance.
  - ccwait held through C2C2.
- MEMRD1/MEMRD2:
  - ramREN=1, ramaddr=daddr[g], dload[g]=ramload.
  - On ACCESS: dwait[g]=0, advance.
- IMEM:
  - ramREN=1, ramaddr=iaddr[g], iload[g]=ramload.
  - On ACCESS: iwait[g]=0, return to IDLE.
- Word advance: the requesting cache advances daddr between words; the controller does not add 4.
- ramstate BUSY/FREE: hold all outputs, no wait released. ERROR is treated as BUSY.
- Requester drops its request mid-transaction: ignored; the controller completes the block.
- Only one RAM transaction is outstanding at a time.
- Minimum latency: snoop miss 1 + 2 RAM accesses; write-back 2 accesses; instruction 1 access.

Decomposition:
- Add to custom_types_pkg:
  - bus_state_t enum, replacing memory_control_t;
  - parameter CACHES;
  - coherence_t.arb resized to ARB_W.
- Sub-module rr_arbiter (params N, W): request vector + pointer in, grant index + valid out, purely combinational. Instantiated twice (dcache class, icache class); pointer registers live in the parent.

Test Plan:
- CACHES=4, RAM latency 2: iREN=4'b1111 continuously -> grants 1,2,3,0,1 in order; each iwait pulse follows 2 BUSY cycles.
- dREN[2]=1 with daddr=0x100 while iREN[0]=1 -> dcache served first. Sequence: SNOOP with ccwait=4'b1011, ccsnoopaddr=0x100; no cctrans; MEMRD words from 0x100/0x104; then IMEM for core 0.
- dREN[1], ccwrite[1]=1, cctrans[3]=1, dstore[3]=0xDEADBEEF -> ccinv=4'b1101. C2C: RAM written 0xDEADBEEF, dload[1]=0xDEADBEEF, dwait[1] and dwait[3] low on the same cycles.
- cctrans[0] and cctrans[3] both high on a dREN[2] miss -> supplier 0 used.
- dWEN[0] and dREN[0] together -> WB1/WB2 complete before SNOOP; RAM holds dstore values at daddr.
- nRST low during MEMRD2 -> next cycle state IDLE, dwait=4'b1111, ramREN=0; the request reissued after reset restarts at SNOOP.
